// File: rtl/pin_pulse_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pin_pulse_pkg
//  Purpose  : Shared state encoding and default widths for the pin pulse
//             generator and its timer.
//  Revision : 1.0  initial release
// ============================================================================
package pin_pulse_pkg;

   // Default width of the half-period timer and of half_period
   localparam int CNT_W_DEF  = 32;
   // Default width of burst_len and pulse_cnt
   localparam int PCNT_W_DEF = 16;
   // Value the LED rotation register takes out of reset
   localparam logic [3:0] LED_RESET = 4'b0001;

   // Train sequencer states; pin_out is high only while in HIGH
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2,
      FIN  = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/pulse_timer.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_timer
//  Purpose  : Loadable down-counter timing one phase of the pulse train.
//             Loaded with H-1 on phase entry; expired flags the final cycle
//             of the phase (count == 0). Never wraps below zero.
//  Revision : 1.0  initial release
// ============================================================================
module pulse_timer #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         expired
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: load has priority, otherwise decrement while enabled and non-zero
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // Count register, cleared by reset
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/pin_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pin_pulse_gen
//  Purpose  : Generates a 50% duty pulse train on pin_out with a programmable
//             half period H = max(half_period, 1) and burst length
//             (0 = continuous). Supports abort via stop and a done strobe.
//  Config   : PIN_PULSE_LED_EN - when defined, led is a one-hot pattern that
//             rotates on every completed pulse; otherwise led is tied to 0.
//  Revision : 1.0  initial release
// ============================================================================
module pin_pulse_gen
   import pin_pulse_pkg::*;
#(
   parameter int CNT_W  = CNT_W_DEF,
   parameter int PCNT_W = PCNT_W_DEF
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              start,
   input  logic              stop,
   input  logic [CNT_W-1:0]  half_period,
   input  logic [PCNT_W-1:0] burst_len,
   output logic              pin_out,
   output logic              busy,
   output logic              done,
   output logic [PCNT_W-1:0] pulse_cnt,
   output logic [3:0]        led
);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    h_q, h_d;
   logic [PCNT_W-1:0]   burst_q, burst_d;
   logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
   logic [PCNT_W-1:0]   pcnt_inc;
   logic                pin_q, pin_d;

   logic                tmr_load;
   logic [CNT_W-1:0]    tmr_load_val;
   logic                tmr_en;
   logic                tmr_expired;

   pulse_timer #(
      .W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .nrst     (nrst),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .en       (tmr_en),
      .expired  (tmr_expired)
   );

   assign pcnt_inc = pcnt_q + PCNT_W'(1);

   // Sequencer next-state, parameter latching, pulse counting and timer control
   always_comb begin
      state_d      = state_q;
      h_d          = h_q;
      burst_d      = burst_q;
      pcnt_d       = pcnt_q;
      tmr_load     = 1'b0;
      tmr_load_val = h_q - CNT_W'(1);
      tmr_en       = 1'b0;

      case (state_q)
         IDLE: begin
            // start together with stop is deliberately ignored
            if (start && !stop) begin
               state_d      = HIGH;
               h_d          = (half_period == '0) ? CNT_W'(1) : half_period;
               burst_d      = burst_len;
               pcnt_d       = '0;
               tmr_load     = 1'b1;
               tmr_load_val = h_d - CNT_W'(1);
            end
         end
         HIGH: begin
            if (stop) begin
               state_d = FIN;
            end else if (tmr_expired) begin
               state_d  = LOW;
               tmr_load = 1'b1;
            end else begin
               tmr_en = 1'b1;
            end
         end
         LOW: begin
            // stop wins over a coincident phase end: the partial pulse is not counted
            if (stop) begin
               state_d = FIN;
            end else if (tmr_expired) begin
               pcnt_d = pcnt_inc;
               if ((burst_q != '0) && (pcnt_inc == burst_q)) begin
                  state_d = FIN;
               end else begin
                  state_d  = HIGH;
                  tmr_load = 1'b1;
               end
            end else begin
               tmr_en = 1'b1;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      pin_d = (state_d == HIGH);
   end

   // Sequencer and datapath registers
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
         h_q     <= '0;
         burst_q <= '0;
         pcnt_q  <= '0;
         pin_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         h_q     <= h_d;
         burst_q <= burst_d;
         pcnt_q  <= pcnt_d;
         pin_q   <= pin_d;
      end
   end

   assign pin_out   = pin_q;
   assign busy      = (state_q == HIGH) || (state_q == LOW);
   assign done      = (state_q == FIN);
   assign pulse_cnt = pcnt_q;

`ifdef PIN_PULSE_LED_EN
   logic [3:0] led_q, led_d;
   logic       led_adv;

   // A pulse completes exactly when LOW ends on the timer without a stop
   assign led_adv = (state_q == LOW) && !stop && tmr_expired;

   // Rotate the one-hot pattern on every pulse count increment
   always_comb begin
      led_d = led_q;
      if (led_adv) begin
         led_d = {led_q[2:0], led_q[3]};
      end
   end

   // LED rotation register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         led_q <= LED_RESET;
      end else begin
         led_q <= led_d;
      end
   end

   assign led = led_q;
`else
   assign led = 4'b0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pin_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pin_pulse_gen
//  Purpose  : Directed self-checking bench for pin_pulse_gen. A second
//             instance with PCNT_W = 4 exercises pulse count wrap.
//  Config   : honours PIN_PULSE_LED_EN for led expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pin_pulse_gen;

`ifdef PIN_PULSE_LED_EN
   localparam logic [3:0] LED_RST_EXP = 4'b0001;
   localparam logic [3:0] LED_AFT5    = 4'b0010;
`else
   localparam logic [3:0] LED_RST_EXP = 4'b0000;
   localparam logic [3:0] LED_AFT5    = 4'b0000;
`endif

   logic        clk = 1'b0;
   logic        nrst;
   logic        start, stop;
   logic [31:0] half_period;
   logic [15:0] burst_len;
   logic        pin_out, busy, done;
   logic [15:0] pulse_cnt;
   logic [3:0]  led;

   logic        start2, stop2;
   logic [31:0] hp2;
   logic [3:0]  bl2;
   logic        pin2, busy2, done2;
   logic [3:0]  pc2;
   logic [3:0]  led2;

   int tests  = 0;
   int failed = 0;

   pin_pulse_gen dut (
      .clk(clk), .nrst(nrst), .start(start), .stop(stop),
      .half_period(half_period), .burst_len(burst_len),
      .pin_out(pin_out), .busy(busy), .done(done),
      .pulse_cnt(pulse_cnt), .led(led)
   );

   pin_pulse_gen #(.CNT_W(32), .PCNT_W(4)) dut_w4 (
      .clk(clk), .nrst(nrst), .start(start2), .stop(stop2),
      .half_period(hp2), .burst_len(bl2),
      .pin_out(pin2), .busy(busy2), .done(done2),
      .pulse_cnt(pc2), .led(led2)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      nrst = 1'b0;
      repeat (2) @(negedge clk);
      tests++; if (pin_out !== 1'b0) begin failed++; $display("FAIL reset_pin got=%b exp=0", pin_out); end
      tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
      tests++; if (done !== 1'b0) begin failed++; $display("FAIL reset_done got=%b exp=0", done); end
      tests++; if (pulse_cnt !== 16'd0) begin failed++; $display("FAIL reset_cnt got=%0d exp=0", pulse_cnt); end
      tests++; if (led !== LED_RST_EXP) begin failed++; $display("FAIL reset_led got=%b exp=%b", led, LED_RST_EXP); end
      tests++; if (led2 !== LED_RST_EXP) begin failed++; $display("FAIL reset_led2 got=%b exp=%b", led2, LED_RST_EXP); end
      nrst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_burst();
      logic [11:0] pat = 12'b111000111000;
      @(negedge clk);
      half_period = 32'd3; burst_len = 16'd2; start = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         start = 1'b0;
         tests++; if (pin_out !== pat[11-i]) begin failed++; $display("FAIL burst_pin[%0d] got=%b exp=%b", i, pin_out, pat[11-i]); end
         tests++; if (busy !== 1'b1) begin failed++; $display("FAIL burst_busy[%0d] got=%b exp=1", i, busy); end
      end
      @(negedge clk);
      tests++; if (done !== 1'b1) begin failed++; $display("FAIL burst_done got=%b exp=1", done); end
      tests++; if (pulse_cnt !== 16'd2) begin failed++; $display("FAIL burst_cnt got=%0d exp=2", pulse_cnt); end
      tests++; if (busy !== 1'b0) begin failed++; $display("FAIL burst_busy_fin got=%b exp=0", busy); end
      tests++; if (pin_out !== 1'b0) begin failed++; $display("FAIL burst_pin_fin got=%b exp=0", pin_out); end
      @(negedge clk);
      tests++; if (done !== 1'b0) begin failed++; $display("FAIL burst_done_clr got=%b exp=0", done); end
      tests++; if (busy !== 1'b0) begin failed++; $display("FAIL burst_idle_busy got=%b exp=0", busy); end
   endtask

   task automatic test_zero_period();
      @(negedge clk);
      half_period = 32'd0; burst_len = 16'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      tests++; if (pin_out !== 1'b1) begin failed++; $display("FAIL zero_pin_hi got=%b exp=1", pin_out); end
      @(negedge clk);
      tests++; if (pin_out !== 1'b0) begin failed++; $display("FAIL zero_pin_lo got=%b exp=0", pin_out); end
      tests++; if (busy !== 1'b1) begin failed++; $display("FAIL zero_busy got=%b exp=1", busy); end
      @(negedge clk);
      tests++; if (done !== 1'b1) begin failed++; $display("FAIL zero_done got=%b exp=1", done); end
      tests++; if (pulse_cnt !== 16'd1) begin failed++; $display("FAIL zero_cnt got=%0d exp=1", pulse_cnt); end
      @(negedge clk);
      tests++; if (done !== 1'b0) begin failed++; $display("FAIL zero_done_clr got=%b exp=0", done); end
   endtask

   task automatic test_stop_mid_high();
      logic exp_pin;
      @(negedge clk);
      half_period = 32'd10; burst_len = 16'd0; start = 1'b1;
      for (int i = 1; i <= 45; i++) begin
         @(negedge clk);
         start = 1'b0;
         // mid-train start and parameter changes must be ignored
         if (i == 20) begin start = 1'b1; half_period = 32'd2; burst_len = 16'd1; end
         exp_pin = (((i - 1) % 20) < 10);
         tests++; if (pin_out !== exp_pin) begin failed++; $display("FAIL stop_pin[%0d] got=%b exp=%b", i, pin_out, exp_pin); end
      end
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      tests++; if (pin_out !== 1'b0) begin failed++; $display("FAIL stop_pin_after got=%b exp=0", pin_out); end
      tests++; if (done !== 1'b1) begin failed++; $display("FAIL stop_done got=%b exp=1", done); end
      tests++; if (pulse_cnt !== 16'd2) begin failed++; $display("FAIL stop_cnt got=%0d exp=2", pulse_cnt); end
      tests++; if (busy !== 1'b0) begin failed++; $display("FAIL stop_busy got=%b exp=0", busy); end
      @(negedge clk);
      tests++; if (done !== 1'b0) begin failed++; $display("FAIL stop_done_clr got=%b exp=0", done); end
   endtask

   task automatic test_start_stop_together();
      @(negedge clk);
      half_period = 32'd1; burst_len = 16'd1; start = 1'b1; stop = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         start = 1'b0; stop = 1'b0;
         tests++; if (busy !== 1'b0) begin failed++; $display("FAIL both_busy[%0d] got=%b exp=0", i, busy); end
         tests++; if (pin_out !== 1'b0) begin failed++; $display("FAIL both_pin[%0d] got=%b exp=0", i, pin_out); end
         tests++; if (done !== 1'b0) begin failed++; $display("FAIL both_done[%0d] got=%b exp=0", i, done); end
      end
   endtask

   task automatic test_continuous_wrap();
      logic exp_pin;
      @(negedge clk);
      hp2 = 32'd1; bl2 = 4'd0; start2 = 1'b1;
      for (int i = 1; i <= 33; i++) begin
         @(negedge clk);
         start2 = 1'b0;
         exp_pin = ((i % 2) == 1);
         tests++; if (pin2 !== exp_pin) begin failed++; $display("FAIL wrap_pin[%0d] got=%b exp=%b", i, pin2, exp_pin); end
         if (i == 31) begin
            tests++; if (pc2 !== 4'd15) begin failed++; $display("FAIL wrap_cnt15 got=%0d exp=15", pc2); end
         end
      end
      tests++; if (pc2 !== 4'd0) begin failed++; $display("FAIL wrap_cnt0 got=%0d exp=0", pc2); end
      tests++; if (busy2 !== 1'b1) begin failed++; $display("FAIL wrap_busy got=%b exp=1", busy2); end
      tests++; if (led2 !== LED_RST_EXP) begin failed++; $display("FAIL wrap_led got=%b exp=%b", led2, LED_RST_EXP); end
      stop2 = 1'b1;
      @(negedge clk);
      stop2 = 1'b0;
      tests++; if (done2 !== 1'b1) begin failed++; $display("FAIL wrap_done got=%b exp=1", done2); end
      tests++; if (pin2 !== 1'b0) begin failed++; $display("FAIL wrap_pin_stop got=%b exp=0", pin2); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_train();
      logic exp_pin;
      @(negedge clk);
      half_period = 32'd2; burst_len = 16'd5; start = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         start = 1'b0;
         exp_pin = (((i - 1) % 4) < 2);
         tests++; if (pin_out !== exp_pin) begin failed++; $display("FAIL rmid_pin[%0d] got=%b exp=%b", i, pin_out, exp_pin); end
      end
      #1 nrst = 1'b0;
      #1;
      tests++; if (pin_out !== 1'b0) begin failed++; $display("FAIL rmid_pin got=%b exp=0", pin_out); end
      tests++; if (busy !== 1'b0) begin failed++; $display("FAIL rmid_busy got=%b exp=0", busy); end
      tests++; if (done !== 1'b0) begin failed++; $display("FAIL rmid_done got=%b exp=0", done); end
      tests++; if (pulse_cnt !== 16'd0) begin failed++; $display("FAIL rmid_cnt got=%0d exp=0", pulse_cnt); end
      tests++; if (led !== LED_RST_EXP) begin failed++; $display("FAIL rmid_led got=%b exp=%b", led, LED_RST_EXP); end
      @(posedge clk);
      #1;
      tests++; if (done !== 1'b0) begin failed++; $display("FAIL rmid_done_hold got=%b exp=0", done); end
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      start = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         start = 1'b0;
         exp_pin = (((i - 1) % 4) < 2);
         tests++; if (pin_out !== exp_pin) begin failed++; $display("FAIL rmid_re_pin[%0d] got=%b exp=%b", i, pin_out, exp_pin); end
         tests++; if (busy !== 1'b1) begin failed++; $display("FAIL rmid_re_busy[%0d] got=%b exp=1", i, busy); end
      end
      @(negedge clk);
      tests++; if (done !== 1'b1) begin failed++; $display("FAIL rmid_re_done got=%b exp=1", done); end
      tests++; if (pulse_cnt !== 16'd5) begin failed++; $display("FAIL rmid_re_cnt got=%0d exp=5", pulse_cnt); end
      tests++; if (led !== LED_AFT5) begin failed++; $display("FAIL rmid_re_led got=%b exp=%b", led, LED_AFT5); end
      @(negedge clk);
      tests++; if (done !== 1'b0) begin failed++; $display("FAIL rmid_re_done_clr got=%b exp=0", done); end
   endtask

   initial begin
      nrst = 1'b0;
      start = 1'b0; stop = 1'b0; half_period = '0; burst_len = '0;
      start2 = 1'b0; stop2 = 1'b0; hp2 = '0; bl2 = '0;
      test_reset();
      test_burst();
      test_zero_period();
      test_stop_mid_high();
      test_start_stop_together();
      test_continuous_wrap();
      test_reset_mid_train();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
`default_nettype wire
